// File: rtl/lsu_mem_master.sv
// lsu_mem_master
//   Load/store initiator between EX and the 64-bit data memory port.
//   Takes one request at a time, aligns address/data/mask to the 8-byte
//   lane, drives the combinational memory port for exactly one cycle, then
//   holds the extended load result (or fault) until WB accepts it.
//
// Ports
//   clk, rst_n              clock, async active-low reset
//   req_valid/req_ready     request handshake (ready only while idle)
//   req_we/addr/wdata/size/unsigned   request fields
//   resp_valid/resp_ready   response handshake
//   resp_rdata              extended load data (0 for stores and faults)
//   resp_misaligned         fault flag; no memory access was made
//   mem_addr/ce/we/wdata/wmask        memory port (active only in ACCESS)
//   mem_rdata               combinational read data from memory
module lsu_mem_master (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [63:0] req_addr,
    input  logic [63:0] req_wdata,
    input  logic [1:0]  req_size,
    input  logic        req_unsigned,
    output logic        resp_valid,
    input  logic        resp_ready,
    output logic [63:0] resp_rdata,
    output logic        resp_misaligned,
    output logic [63:0] mem_addr,
    output logic        mem_ce,
    output logic        mem_we,
    output logic [63:0] mem_wdata,
    output logic [7:0]  mem_wmask,
    input  logic [63:0] mem_rdata
);

    typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

    // Fields of the in-flight request needed after acceptance.
    typedef struct packed {
        logic       we;
        logic [2:0] off;
        logic [1:0] size;
        logic       uns;
    } req_t;

    state_t      state;
    req_t        req_q;
    logic [63:0] addr_q;
    logic [63:0] wdata_q;
    logic [7:0]  wmask_q;
    logic [63:0] rdata_q;
    logic        mis_q;

    logic        mis_d;
    logic [7:0]  base_mask;
    logic [7:0]  wmask_d;
    logic [63:0] wdata_d;
    logic [63:0] raw;
    logic [63:0] load_d;

    // Request-side decode: alignment check and lane placement of store data.
    always_comb begin
        mis_d     = 1'b0;
        base_mask = 8'hFF;
        case (req_size)
            2'd0: begin mis_d = 1'b0;             base_mask = 8'h01; end
            2'd1: begin mis_d = req_addr[0];      base_mask = 8'h03; end
            2'd2: begin mis_d = |req_addr[1:0];   base_mask = 8'h0F; end
            default: begin mis_d = |req_addr[2:0]; base_mask = 8'hFF; end
        endcase
        wmask_d = base_mask << req_addr[2:0];
        wdata_d = req_wdata << {req_addr[2:0], 3'b000};
    end

    // Load-side extraction from the lane, sign/zero extended.
    always_comb begin
        raw    = mem_rdata >> {req_q.off, 3'b000};
        load_d = raw;
        case (req_q.size)
            2'd0:    load_d = {{56{raw[7]  & ~req_q.uns}}, raw[7:0]};
            2'd1:    load_d = {{48{raw[15] & ~req_q.uns}}, raw[15:0]};
            2'd2:    load_d = {{32{raw[31] & ~req_q.uns}}, raw[31:0]};
            default: load_d = raw;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            req_q   <= '0;
            addr_q  <= '0;
            wdata_q <= '0;
            wmask_q <= '0;
            rdata_q <= '0;
            mis_q   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (req_valid) begin
                        req_q   <= '{we: req_we, off: req_addr[2:0],
                                     size: req_size, uns: req_unsigned};
                        addr_q  <= {req_addr[63:3], 3'b000};
                        wdata_q <= wdata_d;
                        wmask_q <= wmask_d;
                        rdata_q <= '0;
                        mis_q   <= mis_d;
                        // A faulting request skips the memory cycle entirely.
                        state   <= mis_d ? RESP : ACCESS;
                    end
                end
                ACCESS: begin
                    if (!req_q.we) rdata_q <= load_d;
                    state <= RESP;
                end
                RESP: begin
                    if (resp_ready) state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Memory strobes come from the state register alone so the port never
    // follows EX-side glitches, and async reset drops them immediately.
    assign mem_ce          = (state == ACCESS);
    assign mem_we          = mem_ce & req_q.we;
    assign mem_wmask       = mem_ce ? wmask_q : 8'h00;
    assign mem_addr        = addr_q;
    assign mem_wdata       = wdata_q;
    assign req_ready       = (state == IDLE);
    assign resp_valid      = (state == RESP);
    assign resp_rdata      = rdata_q;
    assign resp_misaligned = mis_q;

endmodule

// File: tb/tb_lsu_mem_master.sv
// Testbench for lsu_mem_master: a word memory device, a byte-addressed
// reference model of loads/stores, a per-cycle compare process, and a
// directed test sequence with hand-computed literal results.
module tb_lsu_mem_master;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic        req_we = 1'b0;
    logic [63:0] req_addr = '0;
    logic [63:0] req_wdata = '0;
    logic [1:0]  req_size = '0;
    logic        req_unsigned = 1'b0;
    logic        resp_valid;
    logic        resp_ready = 1'b0;
    logic [63:0] resp_rdata;
    logic        resp_misaligned;
    logic [63:0] mem_addr;
    logic        mem_ce;
    logic        mem_we;
    logic [63:0] mem_wdata;
    logic [7:0]  mem_wmask;
    logic [63:0] mem_rdata;

    always #5 clk = ~clk;

    lsu_mem_master dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
        .req_addr(req_addr), .req_wdata(req_wdata), .req_size(req_size),
        .req_unsigned(req_unsigned),
        .resp_valid(resp_valid), .resp_ready(resp_ready),
        .resp_rdata(resp_rdata), .resp_misaligned(resp_misaligned),
        .mem_addr(mem_addr), .mem_ce(mem_ce), .mem_we(mem_we),
        .mem_wdata(mem_wdata), .mem_wmask(mem_wmask), .mem_rdata(mem_rdata)
    );

    // ---------------- memory device (32 words around 0x80000000) ----------
    logic [63:0] dmem [0:31];
    logic        mem_clr = 1'b1;
    logic        pre_en  = 1'b0;
    logic [4:0]  pre_idx = '0;
    logic [63:0] pre_data = '0;

    assign mem_rdata = dmem[mem_addr[7:3]];

    always @(posedge clk) begin
        if (mem_clr) begin
            for (int i = 0; i < 32; i++) dmem[i] <= '0;
        end else if (pre_en) begin
            dmem[pre_idx] <= pre_data;
        end else if (mem_ce && mem_we) begin
            for (int b = 0; b < 8; b++)
                if (mem_wmask[b]) dmem[mem_addr[7:3]][8*b +: 8] <= mem_wdata[8*b +: 8];
        end
    end

    // ---------------- reference model (byte addressed) ----------------
    logic [7:0]  rmem [0:255];
    logic        exp_we, exp_mis;
    logic [63:0] exp_addr, exp_wdata, exp_rdata;
    logic [7:0]  exp_wmask;

    int checks = 0;
    int failures = 0;
    int ce_total = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [63:0] model_load(input logic [63:0] addr, input logic [1:0] size,
                                               input logic uns);
        logic [63:0] v;
        int nb;
        nb = 1 << size;
        v  = '0;
        for (int b = 0; b < nb; b++) v[8*b +: 8] = rmem[8'(addr[7:0] + 8'(b))];
        if (!uns && nb < 8 && v[8*nb-1])
            for (int k = 8*nb; k < 64; k++) v[k] = 1'b1;
        return v;
    endfunction

    // Compare process: memory port and response against model every cycle.
    always @(negedge clk) begin
        if (rst_n) begin
            if (mem_ce) begin
                ce_total++;
                chk("ce_we", {63'b0, mem_we}, {63'b0, exp_we});
                chk("ce_addr", mem_addr, exp_addr);
                chk("ce_wmask", {56'b0, mem_wmask}, {56'b0, exp_wmask});
                if (exp_we) chk("ce_wdata", mem_wdata, exp_wdata);
            end else begin
                chk("idle_wmask", {56'b0, mem_wmask}, 64'h0);
                chk("idle_we", {63'b0, mem_we}, 64'h0);
            end
            if (resp_valid) begin
                chk("resp_rdata", resp_rdata, exp_rdata);
                chk("resp_mis", {63'b0, resp_misaligned}, {63'b0, exp_mis});
            end
        end
    end

    logic [63:0] cap_addr, cap_wdata;
    logic [7:0]  cap_wmask;

    // Sets model expectations for a request.
    task automatic set_exp(input logic we, input logic [63:0] addr, input logic [63:0] wdata,
                           input logic [1:0] size, input logic uns);
        int nb, off;
        nb  = 1 << size;
        off = int'(addr[2:0]);
        exp_we    = we;
        exp_mis   = (addr & 64'(nb - 1)) != 0;
        exp_addr  = addr & ~64'h7;
        exp_wmask = '0;
        exp_wdata = '0;
        for (int b = 0; b < nb; b++) if (b + off < 8) exp_wmask[b + off] = 1'b1;
        for (int b = 0; b + off < 8; b++) exp_wdata[8*(b+off) +: 8] = wdata[8*b +: 8];
        exp_rdata = (we || exp_mis) ? 64'h0 : model_load(addr, size, uns);
    endtask

    task automatic wait_ready();
        int n = 0;
        while (!req_ready && n < 20) begin @(negedge clk); n++; end
        chk("req_ready_idle", {63'b0, req_ready}, 64'h1);
    endtask

    task automatic do_req(input logic we, input logic [63:0] addr, input logic [63:0] wdata,
                          input logic [1:0] size, input logic uns, input int hold,
                          output logic [63:0] rd);
        int ce0, n;
        set_exp(we, addr, wdata, size, uns);
        @(negedge clk);
        wait_ready();
        ce0 = ce_total;
        req_valid = 1'b1; req_we = we; req_addr = addr; req_wdata = wdata;
        req_size = size; req_unsigned = uns;
        @(posedge clk); #1;
        req_valid = 1'b0;
        @(negedge clk);                                   // cycle N+1
        if (!exp_mis) begin
            chk("n1_ce", {63'b0, mem_ce}, 64'h1);
            chk("n1_resp_valid", {63'b0, resp_valid}, 64'h0);
            cap_addr = mem_addr; cap_wmask = mem_wmask; cap_wdata = mem_wdata;
            @(negedge clk);                               // cycle N+2
        end else begin
            chk("mis_ce", {63'b0, mem_ce}, 64'h0);
        end
        chk("resp_valid_on", {63'b0, resp_valid}, 64'h1);
        chk("req_ready_busy", {63'b0, req_ready}, 64'h0);
        rd = resp_rdata;
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            chk("hold_valid", {63'b0, resp_valid}, 64'h1);
            chk("hold_rdata", resp_rdata, rd);
            chk("hold_ready", {63'b0, req_ready}, 64'h0);
        end
        resp_ready = 1'b1;
        @(negedge clk);
        chk("post_valid", {63'b0, resp_valid}, 64'h0);
        chk("post_ready", {63'b0, req_ready}, 64'h1);
        resp_ready = 1'b0;
        n = ce_total - ce0;
        chk("ce_count", 64'(n), exp_mis ? 64'h0 : 64'h1);
        if (we && !exp_mis)
            for (int b = 0; b < (1 << size); b++) rmem[8'(addr[7:0] + 8'(b))] = wdata[8*b +: 8];
    endtask

    task automatic preload(input logic [63:0] addr, input logic [63:0] data);
        @(negedge clk);
        pre_en = 1'b1; pre_idx = addr[7:3]; pre_data = data;
        for (int b = 0; b < 8; b++) rmem[{addr[7:3], 3'(b)}] = data[8*b +: 8];
        @(negedge clk);
        pre_en = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [63:0] rd;
        for (int i = 0; i < 256; i++) rmem[i] = 8'h00;
        exp_we = 0; exp_mis = 0; exp_addr = 0; exp_wdata = 0; exp_rdata = 0; exp_wmask = 0;

        // Reset state
        #3;
        chk("rst_ce", {63'b0, mem_ce}, 64'h0);
        chk("rst_we", {63'b0, mem_we}, 64'h0);
        chk("rst_wmask", {56'b0, mem_wmask}, 64'h0);
        chk("rst_addr", mem_addr, 64'h0);
        chk("rst_wdata", mem_wdata, 64'h0);
        chk("rst_resp_valid", {63'b0, resp_valid}, 64'h0);
        chk("rst_rdata", resp_rdata, 64'h0);
        chk("rst_mis", {63'b0, resp_misaligned}, 64'h0);
        chk("rst_req_ready", {63'b0, req_ready}, 64'h1);
        repeat (3) @(negedge clk);
        mem_clr = 1'b0;
        rst_n   = 1'b1;

        // Dword store then load
        do_req(1'b1, 64'h80000008, 64'h1122334455667788, 2'd3, 1'b0, 0, rd);
        chk("lit_st_addr", cap_addr, 64'h80000008);
        chk("lit_st_wmask", {56'b0, cap_wmask}, 64'hFF);
        do_req(1'b0, 64'h80000008, 64'h0, 2'd3, 1'b0, 0, rd);
        chk("lit_ld_dword", rd, 64'h1122334455667788);

        // Byte store at offset 5
        do_req(1'b1, 64'h80000005, 64'hAB, 2'd0, 1'b0, 0, rd);
        chk("lit_b5_addr", cap_addr, 64'h80000000);
        chk("lit_b5_wmask", {56'b0, cap_wmask}, 64'h20);
        chk("lit_b5_lane", {56'b0, cap_wdata[47:40]}, 64'hAB);
        chk("lit_st_rdata", rd, 64'h0);

        // Sign/zero extension of a byte
        preload(64'h80000000, 64'h00000000F0000000);
        do_req(1'b0, 64'h80000003, 64'h0, 2'd0, 1'b0, 0, rd);
        chk("lit_lb_signed", rd, 64'hFFFFFFFFFFFFFFF0);
        do_req(1'b0, 64'h80000003, 64'h0, 2'd0, 1'b1, 0, rd);
        chk("lit_lb_unsigned", rd, 64'h00000000000000F0);

        // Misaligned requests
        do_req(1'b0, 64'h80000002, 64'h0, 2'd2, 1'b0, 0, rd);
        chk("lit_mis_word", rd, 64'h0);
        do_req(1'b0, 64'h80000001, 64'h0, 2'd1, 1'b0, 0, rd);
        do_req(1'b1, 64'h80000004, 64'hFFFFFFFFFFFFFFFF, 2'd3, 1'b0, 0, rd);
        do_req(1'b0, 64'h80000000, 64'h0, 2'd3, 1'b0, 0, rd);
        chk("lit_mis_st_nowrite", rd, 64'h00000000F0000000);

        // Word store at offset 4, word/half/byte loads
        do_req(1'b1, 64'h80000014, 64'h0000000087654321, 2'd2, 1'b0, 0, rd);
        chk("lit_sw_wmask", {56'b0, cap_wmask}, 64'hF0);
        do_req(1'b0, 64'h80000014, 64'h0, 2'd2, 1'b0, 0, rd);
        chk("lit_lw_signed", rd, 64'hFFFFFFFF87654321);
        do_req(1'b0, 64'h80000014, 64'h0, 2'd2, 1'b1, 0, rd);
        chk("lit_lw_unsigned", rd, 64'h0000000087654321);
        do_req(1'b0, 64'h80000016, 64'h0, 2'd1, 1'b1, 0, rd);
        chk("lit_lh_unsigned", rd, 64'h8765);
        do_req(1'b0, 64'h80000014, 64'h0, 2'd1, 1'b0, 0, rd);
        chk("lit_lh_signed", rd, 64'h4321);
        do_req(1'b0, 64'h80000017, 64'h0, 2'd0, 1'b0, 0, rd);
        chk("lit_lb_top", rd, 64'hFFFFFFFFFFFFFF87);

        // Backpressure
        do_req(1'b0, 64'h80000008, 64'h0, 2'd3, 1'b1, 5, rd);
        chk("lit_bp_rdata", rd, 64'h1122334455667788);

        // Reset during the memory cycle of a store
        set_exp(1'b1, 64'h80000010, 64'hDEADBEEFCAFEF00D, 2'd3, 1'b0);
        @(negedge clk);
        wait_ready();
        req_valid = 1'b1; req_we = 1'b1; req_addr = 64'h80000010;
        req_wdata = 64'hDEADBEEFCAFEF00D; req_size = 2'd3; req_unsigned = 1'b0;
        @(posedge clk); #1;
        req_valid = 1'b0;
        #1;
        chk("rma_ce_before", {63'b0, mem_ce}, 64'h1);
        rst_n = 1'b0;
        #1;
        chk("rma_ce", {63'b0, mem_ce}, 64'h0);
        chk("rma_resp_valid", {63'b0, resp_valid}, 64'h0);
        chk("rma_wmask", {56'b0, mem_wmask}, 64'h0);
        chk("rma_addr", mem_addr, 64'h0);
        chk("rma_req_ready", {63'b0, req_ready}, 64'h1);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("rma_ready_after", {63'b0, req_ready}, 64'h1);
        do_req(1'b0, 64'h80000008, 64'h0, 2'd3, 1'b0, 0, rd);
        chk("lit_after_reset", rd, 64'h1122334455667788);

        repeat (2) @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
